// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one wb_ram slave among several masters.
// The grant is held for the whole bus cycle; a watchdog errors out stalled strobes.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    input  logic [NUM_MASTERS*30-1:0] m_adr_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               s_dat_o,
    output logic [29:0]               s_adr_o,
    output logic                      s_we_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, OWN} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]       gntIdx_q;
    logic [IDX_W-1:0]       rrPtr_q;
    logic [CNT_W-1:0]       wdCount_q;

    logic                   reqFound_d;
    logic [IDX_W-1:0]       nextIdx_d;
    logic [NUM_MASTERS-1:0] grantOh_d;
    logic [IDX_W-1:0]       candIdx;
    logic                   own;
    logic                   gCyc;
    logic                   gStb;
    logic                   errPulse;

    // First requester after the last owner, wrapping modulo NUM_MASTERS
    always_comb begin
        reqFound_d = 1'b0;
        nextIdx_d  = '0;
        candIdx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            candIdx = IDX_W'((int'(rrPtr_q) + i) % NUM_MASTERS);
            if (!reqFound_d && m_cyc_i[candIdx]) begin
                reqFound_d = 1'b1;
                nextIdx_d  = candIdx;
            end
        end
        grantOh_d = NUM_MASTERS'(1) << nextIdx_d;
    end

    assign own  = (state_q == OWN);
    assign gCyc = m_cyc_i[gntIdx_q];
    assign gStb = m_stb_i[gntIdx_q];

    // A same-cycle ack beats the timeout, so err only fires on a still-unacked strobe
    assign errPulse = (TIMEOUT > 0) && own && gStb && !s_ack_i && (wdCount_q == CNT_LAST);

    assign s_dat_o = own ? m_dat_i[int'(gntIdx_q)*32 +: 32] : '0;
    assign s_adr_o = own ? m_adr_i[int'(gntIdx_q)*30 +: 30] : '0;
    assign s_sel_o = own ? m_sel_i[int'(gntIdx_q)*4 +: 4]   : '0;
    assign s_cti_o = own ? m_cti_i[int'(gntIdx_q)*3 +: 3]   : '0;
    assign s_we_o  = own && m_we_i[gntIdx_q];
    assign s_cyc_o = own && gCyc;
    assign s_stb_o = own && gStb && !errPulse;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (own) begin
            m_ack_o[gntIdx_q] = s_ack_i && gStb && !errPulse;
            m_err_o[gntIdx_q] = errPulse;
        end
    end

    // Arbitration FSM; the pointer moves to the releasing owner so it yields next time
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gntIdx_q  <= '0;
            rrPtr_q   <= IDX_W'(NUM_MASTERS - 1);
            wdCount_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wdCount_q <= '0;
                    if (reqFound_d) begin
                        state_q  <= OWN;
                        gntIdx_q <= nextIdx_d;
                        grant_q  <= grantOh_d;
                    end
                end
                OWN: begin
                    if (!gCyc) begin
                        state_q   <= IDLE;
                        rrPtr_q   <= gntIdx_q;
                        grant_q   <= '0;
                        wdCount_q <= '0;
                    end else if ((TIMEOUT > 0) && s_stb_o && !s_ack_i) begin
                        wdCount_q <= wdCount_q + 1'b1;
                    end else begin
                        wdCount_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one 32-bit Wishbone slave (the on-chip wb_ram) between NUM_MASTERS bus masters, e.g. CPU instruction port, CPU data port and a DMA engine.
- Holds the grant for the full bus cycle (cyc held), so burst and block transfers stay atomic.
- Adds a stall watchdog that signals err to a master whose strobe is not acked within TIMEOUT cycles.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT, 16, cycles of unacked stb before err; 0 disables the watchdog.
- IDX_W, $clog2(NUM_MASTERS), localparam, width of the grant index.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_dat_i  in  NUM_MASTERS*32  master write data, master k at [32k+31:32k].
- m_adr_i  in  NUM_MASTERS*30  master word address (bits 31:2), master k at [30k+29:30k].
- m_we_i  in  NUM_MASTERS  write enables.
- m_sel_i  in  NUM_MASTERS*4  byte selects.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- m_dat_o  out  32  read data, broadcast to all masters (equals s_dat_i).
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err (watchdog).
- s_dat_o  out  32  write data to slave.
- s_adr_o  out  30  word address to slave.
- s_we_o  out  1  write enable to slave.
- s_sel_o  out  4  byte select to slave.
- s_cyc_o  out  1  cycle to slave.
- s_stb_o  out  1  strobe to slave.
- s_cti_o  out  3  cycle type to slave.
- s_dat_i  in  32  read data from slave.
- s_ack_i  in  1  ack from slave.
- grant_o  out  NUM_MASTERS  one-hot current grant, registered.

Behaviour:
- Reset, async on rst_ni low: state=IDLE, grant_o=0, rr pointer=NUM_MASTERS-1 (master 0 wins first), watchdog count=0, m_err_o=0. Outputs derived from the grant are 0: s_cyc_o, s_stb_o, s_we_o, m_ack_o.
- FSM states IDLE, OWN.
- IDLE:
  - All s_* control outputs are 0.
  - If any m_cyc_i is high, choose the first requester scanning ptr+1, ptr+2, ... with wrap modulo NUM_MASTERS.
  - Register the choice in grant_o and go to OWN. Latency is one cycle: request at edge t gives grant at edge t+1.
- OWN, granted index g:
  - s_dat_o/adr/we/sel/cyc/stb/cti are combinational muxes of master g's signals.
  - m_ack_o[g] = s_ack_i & m_stb_i[g] & ~err_pulse. All other acks and errs are 0.
  - Non-granted masters get no ack and must wait.
- Release: when m_cyc_i[g] is sampled low in OWN, go to IDLE, set ptr=g and clear grant_o.
  - One dead cycle always separates owners.
  - A master that re-raises cyc immediately yields to any other pending requester.
- Watchdog, TIMEOUT>0:
  - In OWN, count increments each cycle with s_stb_o=1 and s_ack_i=0.
  - Count clears on ack, on stb low, or on leaving OWN.
  - When count reaches TIMEOUT-1 with still no ack: for one cycle, assert m_err_o[g]=1, force s_stb_o=0 and suppress ack, then clear count. The grant is kept until the master drops cyc.
- Simultaneous events:
  - s_ack_i on the same cycle the timeout would fire: ack wins, no err.
  - cyc drop while the err pulse is active: the release still happens next edge.
- Reset asserted mid-transfer: all outputs drop asynchronously and no partial ack is issued. The pointer is reinitialised.
- A master raising stb without cyc is ignored; arbitration looks only at cyc.

Test Plan:
- Single master: master 1 raises cyc+stb, write adr=0x4, dat=0xDEADBEEF, sel=0xF, and the slave acks after 1 wait. Required: grant_o=0b10 one cycle after cyc, s_adr_o=0x4, m_ack_o=0b10 for exactly the ack cycle, m_ack_o[0]=0.
- Contention fairness: with NUM_MASTERS=3, all cyc held high and each master dropping cyc after one ack and re-raising next cycle. Required: grant order 0,1,2,0,1,2, with s_cyc_o=0 for exactly one cycle between grants.
- Burst hold: master 0 issues a 4-beat cti=3'b010 burst ending with 3'b111 while master 1 requests. Required: master 1 is not granted until master 0 drops cyc, and all 4 acks go to master 0 only.
- Watchdog: TIMEOUT=4, slave never acks. Required: m_err_o[g] pulses once, 4 cycles after stb rose, with s_stb_o=0 that cycle. With stb held, the err repeats every 4 cycles.
- Ack/timeout race: ack arrives on the exact cycle the timeout would fire. Required: m_ack_o=1, m_err_o=0, count cleared.
- Reset mid-burst: drop rst_ni during master 1's second beat. Required: grant_o, s_cyc_o and m_ack_o go to 0 immediately. After release, simultaneous requests from masters 0 and 1 grant master 0 first.
